// File: rtl/jtsdram_emu_if.sv
// jtsdram_emu_if: request/response bundle between the SDRAM checker
// (master) and the SDRAM emulator (slave).
//   prog_*     : single programming port, write or read, with byte mask
//   ba_*       : four read-only bank ports, packed per bank
//   refresh_en : enables the periodic refresh blackout
//   corrupt    : flips data_read bit 0 on read completion
//   data_read  : shared read data, valid with any rdy pulse of a read
interface jtsdram_emu_if;
    logic [21:0]      prog_addr;
    logic [15:0]      prog_data;
    logic [1:0]       prog_mask;
    logic [1:0]       prog_ba;
    logic             prog_we;
    logic             prog_rd;
    logic             prog_ack;
    logic             prog_rdy;
    logic [3:0][21:0] ba_addr;
    logic [3:0]       ba_rd;
    logic [3:0]       ba_ack;
    logic [3:0]       ba_rdy;
    logic             refresh_en;
    logic             corrupt;
    logic [31:0]      data_read;

    modport master (
        output prog_addr, prog_data, prog_mask, prog_ba, prog_we, prog_rd,
        output ba_addr, ba_rd, refresh_en, corrupt,
        input  prog_ack, prog_rdy, ba_ack, ba_rdy, data_read
    );

    modport slave (
        input  prog_addr, prog_data, prog_mask, prog_ba, prog_we, prog_rd,
        input  ba_addr, ba_rd, refresh_en, corrupt,
        output prog_ack, prog_rdy, ba_ack, ba_rdy, data_read
    );
endinterface

// File: rtl/jtsdram_emu.sv
// jtsdram_emu: on-chip SDRAM stand-in answering the prog and 4 bank
// request ports from an internal 4 x 2^AW x 16 memory.
//   clk  : clock
//   rst  : asynchronous reset, active low
//   bus  : jtsdram_emu_if slave side (requests in, ack/rdy/data out)
// Every access goes IDLE -> ACK -> WAIT (LAT-1 cycles) -> RDY; writes land
// in the ACK cycle, reads present {mem[a+1], mem[a]} during RDY.
module jtsdram_emu #(
    parameter int AW      = 8,
    parameter int LAT     = 4,
    parameter int REF_LEN = 8
) (
    input  logic           clk,
    input  logic           rst,
    jtsdram_emu_if.slave   bus
);
    localparam int         DEPTH = 4 << AW;
    localparam int         IW    = AW + 2;
    localparam logic [3:0] WLAST = 4'(LAT > 1 ? LAT - 2 : 0);
    localparam logic [5:0] RLEN  = 6'(REF_LEN);

    typedef enum logic [1:0] {IDLE, ACK, WAIT, RDY} state_t;

    state_t        state, state_nx;
    logic [3:0]    wcnt;
    logic [1:0]    rr;
    logic [5:0]    rcnt;
    logic          g_prog, g_we;
    logic [1:0]    g_bank;
    logic [IW-1:0] g_idx, idx_inc;
    logic [15:0]   wdata;
    logic [1:0]    wmask;
    logic [31:0]   rd_word, data_q, data_out;
    logic [7:0]    mem_lo [DEPTH];
    logic [7:0]    mem_hi [DEPTH];

    logic          prog_req, blackout, hit, grant, rd_done;
    logic [1:0]    pick, cand;

    // Only the low AW address bits select a word; the rest alias.
    logic unused_addr;
    assign unused_addr = ^{bus.prog_addr, bus.ba_addr};

    assign prog_req = bus.prog_we | bus.prog_rd;
    assign blackout = bus.refresh_en && (rcnt < RLEN);
    assign grant    = (prog_req || hit) && !blackout;
    // Second word of a read wraps inside the same bank.
    assign idx_inc  = {g_idx[IW-1:AW], g_idx[AW-1:0] + 1'b1};

    // Round-robin scan; walking offsets downwards leaves the nearest
    // requester (starting at rr) as the final pick.
    always_comb begin
        pick = rr;
        hit  = 1'b0;
        cand = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = rr + 2'(k);
            if (bus.ba_rd[cand]) begin
                pick = cand;
                hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = ACK;
            ACK:     state_nx = (LAT == 1) ? RDY : WAIT;
            WAIT:    if (wcnt == WLAST) state_nx = RDY;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr      <= '0;
            rcnt    <= '0;
            wcnt    <= '0;
            g_prog  <= 1'b0;
            g_we    <= 1'b0;
            g_bank  <= '0;
            g_idx   <= '0;
            wdata   <= '0;
            wmask   <= '0;
            rd_word <= '0;
            data_q  <= '0;
        end else begin
            rcnt <= bus.refresh_en ? rcnt + 6'd1 : 6'd0;
            case (state)
                IDLE: if (grant) begin
                    g_prog <= prog_req;
                    g_we   <= bus.prog_we;
                    g_bank <= prog_req ? bus.prog_ba : pick;
                    g_idx  <= prog_req ? {bus.prog_ba, bus.prog_addr[AW-1:0]}
                                       : {pick, bus.ba_addr[pick][AW-1:0]};
                    wdata  <= bus.prog_data;
                    wmask  <= bus.prog_mask;
                    if (!prog_req) rr <= pick + 2'd1;
                end
                ACK: begin
                    wcnt    <= '0;
                    rd_word <= {mem_hi[idx_inc], mem_lo[idx_inc],
                                mem_hi[g_idx],   mem_lo[g_idx]};
                end
                WAIT:    wcnt <= wcnt + 4'd1;
                default: if (rd_done) data_q <= data_out;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ACK && g_prog && g_we) begin
            if (!wmask[0]) mem_lo[g_idx] <= wdata[7:0];
            if (!wmask[1]) mem_hi[g_idx] <= wdata[15:8];
        end
    end

    // corrupt is applied live in the RDY cycle, then frozen in data_q.
    assign rd_done       = (state == RDY) && !(g_prog && g_we);
    assign data_out      = rd_word ^ {31'b0, bus.corrupt};
    assign bus.data_read = rd_done ? data_out : data_q;

    assign bus.prog_ack = (state == ACK) && g_prog;
    assign bus.prog_rdy = (state == RDY) && g_prog;
    assign bus.ba_ack   = (state == ACK && !g_prog) ? (4'b1 << g_bank) : 4'b0;
    assign bus.ba_rdy   = (state == RDY && !g_prog) ? (4'b1 << g_bank) : 4'b0;
endmodule

// File: tb/tb_jtsdram_emu.sv
module tb_jtsdram_emu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    jtsdram_emu_if bus();

    jtsdram_emu #(.AW(8), .LAT(4), .REF_LEN(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Bank read; cycle counts are negedges from request to ack and from ack
    // to rdy (-1 on timeout). One idle cycle follows so the next request is
    // seen in IDLE.
    task automatic rd_bank(input int n, input logic [21:0] a,
                           output logic [31:0] d, output int ack_c, output int rdy_c);
        ack_c = -1; rdy_c = -1; d = '0;
        bus.ba_addr[n] = a;
        bus.ba_rd[n]   = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.ba_ack[n]) begin ack_c = c; break; end
        end
        bus.ba_rd[n] = 1'b0;
        if (ack_c > 0)
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                if (bus.ba_rdy[n]) begin rdy_c = c; d = bus.data_read; break; end
            end
        @(negedge clk);
    endtask

    task automatic prog_acc(input bit we, input logic [1:0] b, input logic [21:0] a,
                            input logic [15:0] dt, input logic [1:0] m,
                            output logic [31:0] d, output int ack_c, output int rdy_c);
        ack_c = -1; rdy_c = -1; d = '0;
        bus.prog_ba = b; bus.prog_addr = a; bus.prog_data = dt; bus.prog_mask = m;
        bus.prog_we = we; bus.prog_rd = !we;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.prog_ack) begin ack_c = c; break; end
        end
        bus.prog_we = 1'b0; bus.prog_rd = 1'b0;
        if (ack_c > 0)
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                if (bus.prog_rdy) begin rdy_c = c; d = bus.data_read; break; end
            end
        @(negedge clk);
    endtask

    task automatic test_reset;
        bus.prog_addr = '0; bus.prog_data = '0; bus.prog_mask = '0; bus.prog_ba = '0;
        bus.prog_we = 1'b0; bus.prog_rd = 1'b0; bus.ba_addr = '0; bus.ba_rd = '0;
        bus.refresh_en = 1'b0; bus.corrupt = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.prog_ack, bus.prog_rdy} !== 2'b00) begin
            failures++; $display("FAIL reset_prog got=%b want=00", {bus.prog_ack, bus.prog_rdy});
        end
        checks++;
        if ({bus.ba_ack, bus.ba_rdy} !== 8'h00) begin
            failures++; $display("FAIL reset_bank got=%h want=00", {bus.ba_ack, bus.ba_rdy});
        end
        checks++;
        if (bus.data_read !== 32'h0) begin
            failures++; $display("FAIL reset_data got=%h want=00000000", bus.data_read);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write;
        logic [31:0] d; int ac, rc;
        prog_acc(1'b1, 2'd2, 22'h05, 16'hBEEF, 2'b00, d, ac, rc);
        checks++;
        if (ac !== 1 || rc !== 4) begin
            failures++; $display("FAIL write_latency got=%0d/%0d want=1/4", ac, rc);
        end
        checks++;
        if (d !== 32'h0) begin
            failures++; $display("FAIL write_rdy_data got=%h want=00000000", d);
        end
        rd_bank(2, 22'h05, d, ac, rc);
        checks++;
        if (ac !== 1 || rc !== 4) begin
            failures++; $display("FAIL read_latency got=%0d/%0d want=1/4", ac, rc);
        end
        checks++;
        if (d[15:0] !== 16'hBEEF) begin
            failures++; $display("FAIL read_data got=%h want=BEEF", d[15:0]);
        end
    endtask

    task automatic test_masked;
        logic [31:0] d; int ac, rc;
        prog_acc(1'b1, 2'd2, 22'h05, 16'h1234, 2'b10, d, ac, rc);
        rd_bank(2, 22'h05, d, ac, rc);
        checks++;
        if (d[15:0] !== 16'hBE34) begin
            failures++; $display("FAIL mask_lo got=%h want=BE34", d[15:0]);
        end
        prog_acc(1'b1, 2'd2, 22'h05, 16'h5678, 2'b11, d, ac, rc);
        checks++;
        if (rc !== 4) begin
            failures++; $display("FAIL mask_none_rdy got=%0d want=4", rc);
        end
        rd_bank(2, 22'h05, d, ac, rc);
        checks++;
        if (d[15:0] !== 16'hBE34) begin
            failures++; $display("FAIL mask_none got=%h want=BE34", d[15:0]);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] d; int ac, rc;
        prog_acc(1'b1, 2'd3, 22'h0FF, 16'h1111, 2'b00, d, ac, rc);
        prog_acc(1'b1, 2'd3, 22'h000, 16'h2222, 2'b00, d, ac, rc);
        rd_bank(3, 22'h0FF, d, ac, rc);
        checks++;
        if (d !== 32'h22221111) begin
            failures++; $display("FAIL wrap got=%h want=22221111", d);
        end
        bus.corrupt = 1'b1;
        rd_bank(3, 22'h0FF, d, ac, rc);
        bus.corrupt = 1'b0;
        checks++;
        if (d !== 32'h22221110) begin
            failures++; $display("FAIL corrupt got=%h want=22221110", d);
        end
        // data_read holds the corrupted value until the next read rdy
        checks++;
        if (bus.data_read !== 32'h22221110) begin
            failures++; $display("FAIL hold got=%h want=22221110", bus.data_read);
        end
        prog_acc(1'b0, 2'd3, 22'h0FF, 16'h0, 2'b00, d, ac, rc);
        checks++;
        if (d !== 32'h22221111 || rc !== 4) begin
            failures++; $display("FAIL prog_read got=%h/%0d want=22221111/4", d, rc);
        end
        rd_bank(3, 22'h3FFF00, d, ac, rc);
        checks++;
        if (d[15:0] !== 16'h2222) begin
            failures++; $display("FAIL alias got=%h want=2222", d[15:0]);
        end
    endtask

    task automatic test_round_robin;
        int when [4]; int order [4]; int n; bit multi;
        n = 0; multi = 1'b0;
        for (int i = 0; i < 4; i++) begin when[i] = -1; order[i] = -1; end
        rst = 1'b0;
        bus.ba_addr = '0;
        bus.ba_rd = 4'hF;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if ($countones({bus.ba_ack, bus.prog_ack}) > 1) multi = 1'b1;
            for (int b = 0; b < 4; b++)
                if (bus.ba_ack[b] && n < 4) begin
                    order[n] = b; when[n] = c; n++;
                    bus.ba_rd[b] = 1'b0;
                end
        end
        bus.ba_rd = '0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (order[i] !== i || when[i] !== 1 + 6 * i) begin
                failures++;
                $display("FAIL rr_grant%0d got=ba%0d@%0d want=ba%0d@%0d",
                         i, order[i], when[i], i, 1 + 6 * i);
            end
        end
        checks++;
        if (multi) begin
            failures++; $display("FAIL rr_onehot got=multiple want=single");
        end
    endtask

    task automatic test_prog_priority;
        int pa, pr, a0, a1;
        pa = -1; pr = -1; a0 = -1; a1 = -1;
        bus.prog_ba = 2'd0; bus.prog_addr = 22'h80; bus.prog_data = 16'hA5A5;
        bus.prog_mask = 2'b00; bus.prog_we = 1'b1;
        bus.ba_addr[0] = 22'h0; bus.ba_addr[1] = 22'h0;
        bus.ba_rd = 4'b0011;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.prog_ack)  begin pa = c; bus.prog_we = 1'b0; end
            if (bus.prog_rdy)  pr = c;
            if (bus.ba_ack[0]) begin a0 = c; bus.ba_rd[0] = 1'b0; end
            if (bus.ba_ack[1]) begin a1 = c; bus.ba_rd[1] = 1'b0; end
        end
        bus.prog_we = 1'b0; bus.ba_rd = '0;
        checks++;
        if (pa !== 1 || pr !== 5) begin
            failures++; $display("FAIL prio_prog got=%0d/%0d want=1/5", pa, pr);
        end
        checks++;
        if (a0 !== 7) begin
            failures++; $display("FAIL prio_ba0 got=%0d want=7", a0);
        end
        checks++;
        if (a1 !== 13) begin
            failures++; $display("FAIL prio_ba1 got=%0d want=13", a1);
        end
    endtask

    task automatic test_refresh;
        logic [31:0] d; int ac, rc;
        bus.refresh_en = 1'b1;
        rd_bank(0, 22'h80, d, ac, rc);
        bus.refresh_en = 1'b0;
        checks++;
        if (ac !== 9) begin
            failures++; $display("FAIL refresh_ack got=%0d want=9", ac);
        end
        checks++;
        if (rc !== 4 || d[15:0] !== 16'hA5A5) begin
            failures++; $display("FAIL refresh_read got=%0d/%h want=4/A5A5", rc, d[15:0]);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d; int ac, rc; bit seen_ack; bit seen_rdy;
        seen_ack = 1'b0; seen_rdy = 1'b0;
        bus.ba_addr[2] = 22'h05; bus.ba_rd[2] = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.ba_ack[2]) begin seen_ack = 1'b1; break; end
        end
        bus.ba_rd[2] = 1'b0;
        checks++;
        if (!seen_ack) begin
            failures++; $display("FAIL rstmid_ack got=none want=ack");
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.ba_ack, bus.ba_rdy, bus.prog_ack, bus.prog_rdy} !== 10'h0 ||
            bus.data_read !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%h/%h want=0/00000000",
                     {bus.ba_ack, bus.ba_rdy}, bus.data_read);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.ba_rdy !== 4'h0) seen_rdy = 1'b1;
        end
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.ba_rdy !== 4'h0 || bus.ba_ack !== 4'h0) seen_rdy = 1'b1;
        end
        checks++;
        if (seen_rdy) begin
            failures++; $display("FAIL rstmid_abort got=activity want=quiet");
        end
        rd_bank(2, 22'h05, d, ac, rc);
        checks++;
        if (ac !== 1 || rc !== 4 || d[15:0] !== 16'hBE34) begin
            failures++;
            $display("FAIL rstmid_reissue got=%0d/%0d/%h want=1/4/BE34", ac, rc, d[15:0]);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_masked();
        test_wrap();
        test_round_robin();
        test_prog_priority();
        test_refresh();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
